// File: rtl/regfile_pkg.sv
// Shared register-file defaults and the two-port write priority resolver.
// Imported by the datapath and by its bench.
package regfile_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 4;
    localparam int DEF_SPECIAL_IDX = 15;

    typedef struct packed {
        logic wr1;
        logic wr2;
        logic conflict;
    } wr_grant_t;

    // Port 2 wins when both ports target the same register.
    function automatic wr_grant_t wr_resolve(input logic en1, input logic en2, input logic same_addr);
        wr_grant_t g;
        g.wr1      = en1 && !(en2 && same_addr);
        g.wr2      = en2;
        g.conflict = en1 && en2 && same_addr;
        return g;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: writes clear, reserves set (reserve wins), rsv_err flags re-reserve.
// Latency: busy updates at the edge, rsv_err registered one cycle; REGFILE_BYPASS_EN masks busy on same-cycle writes.
// Backpressure: none, callers gate issue on rd_busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              rsv_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            if (wr_en1) busy[wr_addr1] <= 1'b0;
            if (wr_en2) busy[wr_addr2] <= 1'b0;
            // Applied last so a reserve overrides a same-cycle clear.
            if (rsv_en) busy[rsv_addr] <= 1'b1;
            rsv_err <= rsv_en && busy[rsv_addr];
        end
    end

`ifdef REGFILE_BYPASS_EN
    function automatic logic busy_view(input logic [DEPTH-1:0] b, input logic [ADDR_W-1:0] ra,
                                       input logic we1, input logic [ADDR_W-1:0] wa1,
                                       input logic we2, input logic [ADDR_W-1:0] wa2,
                                       input logic re, input logic [ADDR_W-1:0] radr);
        logic hit;
        hit = (we1 && (wa1 == ra)) || (we2 && (wa2 == ra));
        if (hit && !(re && (radr == ra)))
            return 1'b0;
        return b[ra];
    endfunction

    always_comb begin
        rd_busy1 = busy_view(busy, rd_addr1, wr_en1, wr_addr1, wr_en2, wr_addr2, rsv_en, rsv_addr);
        rd_busy2 = busy_view(busy, rd_addr2, wr_en1, wr_addr1, wr_en2, wr_addr2, rsv_en, rsv_addr);
    end
`else
    always_comb begin
        rd_busy1 = busy[rd_addr1];
        rd_busy2 = busy[rd_addr2];
    end
`endif

endmodule

// File: rtl/regfile_sb.sv
// Two-read/two-write register file with busy scoreboard and a special-register tap (option: REGFILE_BYPASS_EN).
// Latency: writes land at the edge, reads combinational; wr_conflict/rsv_err registered one cycle.
// Backpressure: none, the block accepts every write and reserve each cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SPECIAL_IDX = DEF_SPECIAL_IDX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en1,
    input  logic              wr_en2,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [ADDR_W-1:0] wr_addr2,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic [DATA_W-1:0] wr_data2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              wr_conflict,
    output logic              rsv_err,
    output logic [DATA_W-1:0] special_data,
    output logic [ADDR_W-1:0] special_addr
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SPECIAL_A = ADDR_W'(SPECIAL_IDX);

    logic [DATA_W-1:0] mem [DEPTH];
    wr_grant_t         grant;

    assign grant        = wr_resolve(wr_en1, wr_en2, wr_addr1 == wr_addr2);
    assign special_addr = SPECIAL_A;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_conflict <= 1'b0;
        end else begin
            if (grant.wr1) mem[wr_addr1] <= wr_data1;
            if (grant.wr2) mem[wr_addr2] <= wr_data2;
            wr_conflict <= grant.conflict;
        end
    end

`ifdef REGFILE_BYPASS_EN
    function automatic logic [DATA_W-1:0] bypass(input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] arr,
                                                  input logic we1, input logic [ADDR_W-1:0] wa1,
                                                  input logic [DATA_W-1:0] wd1,
                                                  input logic we2, input logic [ADDR_W-1:0] wa2,
                                                  input logic [DATA_W-1:0] wd2);
        if (we2 && (wa2 == ra)) return wd2;
        if (we1 && (wa1 == ra)) return wd1;
        return arr;
    endfunction

    always_comb begin
        rd_data1     = bypass(rd_addr1, mem[rd_addr1], wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
        rd_data2     = bypass(rd_addr2, mem[rd_addr2], wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
        special_data = bypass(SPECIAL_A, mem[SPECIAL_A], wr_en1, wr_addr1, wr_data1, wr_en2, wr_addr2, wr_data2);
    end
`else
    always_comb begin
        rd_data1     = mem[rd_addr1];
        rd_data2     = mem[rd_addr2];
        special_data = mem[SPECIAL_A];
    end
`endif

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .wr_en1   (wr_en1),
        .wr_addr1 (wr_addr1),
        .wr_en2   (wr_en2),
        .wr_addr2 (wr_addr2),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_busy1 (rd_busy1),
        .rd_busy2 (rd_busy2),
        .rsv_err  (rsv_err)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: vector table with an expected-result queue plus hand sequences for reset and bypass.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = DEF_DATA_W;
    localparam int AW = DEF_ADDR_W;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2;
    logic          wr_en1, wr_en2;
    logic [AW-1:0] wr_addr1, wr_addr2;
    logic [DW-1:0] wr_data1, wr_data2;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;
    logic          wr_conflict, rsv_err;
    logic [DW-1:0] special_data;
    logic [AW-1:0] special_addr;

    regfile_sb dut (
        .clk(clk), .reset(reset),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .wr_en1(wr_en1), .wr_en2(wr_en2),
        .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
        .wr_data1(wr_data1), .wr_data2(wr_data2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .wr_conflict(wr_conflict), .rsv_err(rsv_err),
        .special_data(special_data), .special_addr(special_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we1; logic [AW-1:0] wa1; logic [DW-1:0] wd1;
        logic          we2; logic [AW-1:0] wa2; logic [DW-1:0] wd2;
        logic          rsv; logic [AW-1:0] radr;
        logic [AW-1:0] ra1; logic [AW-1:0] ra2;
        logic [DW-1:0] d1;  logic [DW-1:0] d2;
        logic          b1;  logic b2; logic conf; logic err;
        logic [DW-1:0] sp;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d1; logic [DW-1:0] d2;
        logic b1; logic b2; logic conf; logic err;
        logic [DW-1:0] sp;
    } exp_t;

    vec_t vecs[13];
    exp_t expq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic we1, int wa1, int wd1, logic we2, int wa2, int wd2,
                                logic rsv, int radr, int ra1, int ra2,
                                int d1, int d2, logic b1, logic b2, logic conf, logic err, int sp);
        vec_t v;
        v.we1 = we1; v.wa1 = AW'(wa1); v.wd1 = DW'(wd1);
        v.we2 = we2; v.wa2 = AW'(wa2); v.wd2 = DW'(wd2);
        v.rsv = rsv; v.radr = AW'(radr);
        v.ra1 = AW'(ra1); v.ra2 = AW'(ra2);
        v.d1 = DW'(d1); v.d2 = DW'(d2);
        v.b1 = b1; v.b2 = b2; v.conf = conf; v.err = err; v.sp = DW'(sp);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en1 = 1'b0; wr_en2 = 1'b0; rsv_en = 1'b0;
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        v = vecs[idx];
        @(negedge clk);
        wr_en1 = v.we1; wr_addr1 = v.wa1; wr_data1 = v.wd1;
        wr_en2 = v.we2; wr_addr2 = v.wa2; wr_data2 = v.wd2;
        rsv_en = v.rsv; rsv_addr = v.radr;
        rd_addr1 = v.ra1; rd_addr2 = v.ra2;
        e.d1 = v.d1; e.d2 = v.d2; e.b1 = v.b1; e.b2 = v.b2;
        e.conf = v.conf; e.err = v.err; e.sp = v.sp;
        expq.push_back(e);
        @(posedge clk);
        #1 idle_inputs();
        #1;
        if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL v%0d scoreboard empty", idx);
        end else begin
            e = expq.pop_front();
            check($sformatf("v%0d rd_data1", idx), 32'(rd_data1), 32'(e.d1));
            check($sformatf("v%0d rd_data2", idx), 32'(rd_data2), 32'(e.d2));
            check($sformatf("v%0d rd_busy1", idx), 32'(rd_busy1), 32'(e.b1));
            check($sformatf("v%0d rd_busy2", idx), 32'(rd_busy2), 32'(e.b2));
            check($sformatf("v%0d wr_conflict", idx), 32'(wr_conflict), 32'(e.conf));
            check($sformatf("v%0d rsv_err", idx), 32'(rsv_err), 32'(e.err));
            check($sformatf("v%0d special_data", idx), 32'(special_data), 32'(e.sp));
        end
    endtask

    initial begin
        //            we1 wa1 wd1   we2 wa2 wd2   rsv radr ra1 ra2 | d1    d2    b1 b2 cf er sp
        vecs[0]  = mk(1, 0,  1000, 1, 1,  2000, 0, 0, 0,  1,  1000, 2000, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 15, 5000, 1, 15, 6000, 0, 0, 15, 0,  6000, 1000, 0, 0, 1, 0, 6000);
        vecs[2]  = mk(0, 0,  0,    0, 0,  0,    0, 0, 15, 1,  6000, 2000, 0, 0, 0, 0, 6000);
        vecs[3]  = mk(0, 0,  0,    0, 0,  0,    1, 4, 4,  0,  0,    1000, 1, 0, 0, 0, 6000);
        vecs[4]  = mk(0, 0,  0,    0, 0,  0,    1, 4, 4,  0,  0,    1000, 1, 0, 0, 1, 6000);
        vecs[5]  = mk(1, 4,  7,    0, 0,  0,    0, 0, 4,  0,  7,    1000, 0, 0, 0, 0, 6000);
        vecs[6]  = mk(0, 0,  0,    1, 5,  9,    1, 5, 5,  4,  9,    7,    1, 0, 0, 0, 6000);
        vecs[7]  = mk(1, 5,  11,   1, 6,  12,   1, 6, 5,  6,  11,   12,   0, 1, 0, 0, 6000);
        vecs[8]  = mk(1, 6,  13,   0, 0,  0,    1, 6, 6,  15, 13,   6000, 1, 0, 0, 1, 6000);
        vecs[9]  = mk(1, 3,  100,  1, 3,  200,  0, 0, 3,  6,  200,  13,   0, 1, 1, 0, 6000);
        vecs[10] = mk(1, 3,  300,  1, 3,  400,  0, 0, 3,  6,  400,  13,   0, 1, 1, 0, 6000);
        vecs[11] = mk(0, 0,  0,    0, 0,  0,    0, 0, 3,  6,  400,  13,   0, 1, 0, 0, 6000);
        vecs[12] = mk(1, 15, 42,   0, 0,  0,    0, 0, 15, 3,  42,   400,  0, 0, 0, 0, 42);

        // Reset must override a write presented alongside it.
        reset = 1'b1;
        wr_en1 = 1'b1; wr_addr1 = 4'd3; wr_data1 = 16'd1000;
        wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
        rd_addr1 = 4'd3; rd_addr2 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        #1;
        check("reset reg3", 32'(rd_data1), 32'd0);
        check("reset busy1", 32'(rd_busy1), 32'd0);
        check("reset busy2", 32'(rd_busy2), 32'd0);
        check("reset wr_conflict", 32'(wr_conflict), 32'd0);
        check("reset rsv_err", 32'(rsv_err), 32'd0);
        check("reset special_data", 32'(special_data), 32'd0);
        check("special_addr", 32'(special_addr), 32'd15);

        for (int i = 0; i < 13; i++) run_vec(i);

        // Read during a write, before and after the edge; R2 holds 0, R6 holds 13 and is busy.
        @(negedge clk);
        wr_en1 = 1'b1; wr_addr1 = 4'd2; wr_data1 = 16'd3000;
        wr_en2 = 1'b1; wr_addr2 = 4'd6; wr_data2 = 16'd55;
        rd_addr1 = 4'd2; rd_addr2 = 4'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pre-edge rd_data1", 32'(rd_data1), 32'd3000);
        check("pre-edge rd_data2", 32'(rd_data2), 32'd55);
        check("pre-edge rd_busy2", 32'(rd_busy2), 32'd0);
`else
        check("pre-edge rd_data1", 32'(rd_data1), 32'd0);
        check("pre-edge rd_data2", 32'(rd_data2), 32'd13);
        check("pre-edge rd_busy2", 32'(rd_busy2), 32'd1);
`endif
        @(posedge clk);
        #1 idle_inputs();
        #1;
        check("post-edge rd_data1", 32'(rd_data1), 32'd3000);
        check("post-edge rd_data2", 32'(rd_data2), 32'd55);
        check("post-edge rd_busy2", 32'(rd_busy2), 32'd0);

        @(negedge clk);
        wr_en1 = 1'b1; wr_addr1 = 4'd15; wr_data1 = 16'd77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("pre-edge special_data", 32'(special_data), 32'd77);
`else
        check("pre-edge special_data", 32'(special_data), 32'd42);
`endif
        @(posedge clk);
        #1 idle_inputs();
        #1;
        check("post-edge special_data", 32'(special_data), 32'd77);

        // Mid-run reset with a write and a reserve active clears everything.
        @(negedge clk);
        reset = 1'b1;
        wr_en1 = 1'b1; wr_addr1 = 4'd3; wr_data1 = 16'd1000;
        rsv_en = 1'b1; rsv_addr = 4'd7;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        #1;
        check("reset2 wr_conflict", 32'(wr_conflict), 32'd0);
        check("reset2 rsv_err", 32'(rsv_err), 32'd0);
        check("reset2 special_data", 32'(special_data), 32'd0);
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = AW'(a);
            rd_addr2 = AW'(15 - a);
            #1;
            check($sformatf("reset2 data r%0d", a), 32'(rd_data1), 32'd0);
            check($sformatf("reset2 busy r%0d", a), 32'(rd_busy1), 32'd0);
            check($sformatf("reset2 busy2 r%0d", 15 - a), 32'(rd_busy2), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised two-read/two-write register file with a per-register busy scoreboard and a dedicated special-register tap. It is the next generation of the team's 16x16 register block and sits between decode (reads, reservations) and writeback (writes) in the datapath. It adds configurable width and depth, defined same-address write priority, conflict reporting, and optional write-to-read bypass.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; depth = 2**ADDR_W
- SPECIAL_IDX, 15, index exported on special_data/special_addr; must be < 2**ADDR_W

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock and one reset only
- rd_addr1, rd_addr2  in  ADDR_W  read addresses
- rd_data1, rd_data2  out  DATA_W  read data
- rd_busy1, rd_busy2  out  1  busy bit of the addressed register
- wr_en1, wr_en2  in  1  write enables, active-high
- wr_addr1, wr_addr2  in  ADDR_W  write addresses
- wr_data1, wr_data2  in  DATA_W  write data
- rsv_en  in  1  reserve (mark busy) request
- rsv_addr  in  ADDR_W  register to reserve
- wr_conflict  out  1  registered; both ports wrote the same address last cycle
- rsv_err  out  1  registered; reserve hit an already-busy register last cycle
- special_data  out  DATA_W  current contents of register SPECIAL_IDX
- special_addr  out  ADDR_W  constant SPECIAL_IDX

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W busy bits.
- Reset: all registers 0, all busy bits 0, wr_conflict 0, rsv_err 0. rd_data and special_data therefore read 0 and rd_busy reads 0 from the first cycle after reset. Reset overrides any write or reserve in the same cycle.
- Write: on each edge with wr_enN=1, reg[wr_addrN] <= wr_dataN and busy[wr_addrN] <= 0.
- Same-address writes (both enables set, equal addresses): port 2 wins. wr_conflict = 1 for the following cycle.
- Reserve: rsv_en=1 sets busy[rsv_addr] at the edge.
  - Reserve and write to the same address in one cycle: the reserve wins, so busy ends at 1 and the data is still written.
  - Reserving an already-busy register leaves it busy and sets rsv_err = 1 for the following cycle.
- Read: combinational from the array. rd_busyN = busy[rd_addrN].
- special_data is combinational from reg[SPECIAL_IDX]. It is written like any other register.
- Address arithmetic is unsigned ADDR_W. Out-of-range addresses cannot occur.

## Timing
- Write latency without bypass: data presented at edge k is readable after edge k (0-cycle combinational read thereafter).
- Busy bit: set or cleared at the edge. rd_busy reflects the new value after that edge.
- wr_conflict and rsv_err: asserted exactly one cycle after the causing edge and cleared the next cycle unless the cause repeats.
- No handshake or stall: the block never backpressures. Callers gate issue on rd_busy.

## Configuration
- REGFILE_BYPASS_EN defined: in the same cycle a write is presented, rd_dataN returns the write data if rd_addrN matches an enabled write address (port 2 over port 1), and rd_busyN reads 0 for that address unless rsv_en targets it in the same cycle.
- Bypass also applies to special_data.
- REGFILE_BYPASS_EN undefined: reads show array contents only, so new data is visible the cycle after the write.

## Structure
- Shared package regfile_pkg: default DATA_W/ADDR_W/SPECIAL_IDX constants and a function resolving two-port write priority. The datapath and the bench both import it.
- One natural sub-module: regfile_scoreboard, which holds the busy bits, reserve/clear logic and the rsv_err flag. Data storage, bypass and the conflict flag stay in the top module.

## Test plan
- Reset with wr_en1=1, wr_addr1=3, wr_data1=1000 asserted -> after release, reg3 = 0, all rd_busy = 0, wr_conflict = 0, rsv_err = 0.
- Write R0=1000 (port 1) and R1=2000 (port 2) in one cycle, then read addresses 0 and 1 -> rd_data1 = 1000 and rd_data2 = 2000 on the cycle after the edge.
- Both ports write address 15 with 5000 and 6000 -> register 15 = 6000, special_data = 6000, wr_conflict = 1 for exactly one cycle.
- Reserve R4, read R4 -> rd_busy1 = 1. Reserve R4 again -> rsv_err = 1 for one cycle. Write R4=7 -> rd_busy1 = 0, rd_data1 = 7.
- Reserve and write R5=9 in the same cycle -> rd_busy = 1 and data reads 9.
- With REGFILE_BYPASS_EN: write R2=3000 while reading address 2 in the same cycle -> rd_data = 3000 before the edge. Without the macro -> old value before the edge, 3000 after it.
